// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing arbiter.
// Holds the ALU op-code map (must match the alu_control encoding), the
// arbiter FSM state encoding and op-code legality helpers.
package alu_pkg;

    // ALU control codes as understood by the shared ALU.
    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_SLL     = 4'b0010;
    localparam logic [3:0] ALU_SRL     = 4'b0011;
    localparam logic [3:0] ALU_SRA     = 4'b0100;
    localparam logic [3:0] ALU_AND     = 4'b0101;
    localparam logic [3:0] ALU_OR      = 4'b0110;
    localparam logic [3:0] ALU_XOR     = 4'b0111;
    localparam logic [3:0] ALU_OP_LAST = 4'b0111;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    // True when the code names one of the eight implemented ALU functions.
    function automatic logic alu_op_legal(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL,
            ALU_SRA, ALU_AND, ALU_OR,  ALU_XOR: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Code actually sent to the ALU: unknown codes fall back to add.
    function automatic logic [3:0] alu_op_effective(input logic [3:0] op);
        logic [3:0] eff;
        if (op > ALU_OP_LAST) begin
            eff = ALU_ADD;
        end else begin
            eff = op;
        end
        return eff;
    endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational two-way request picker.
// Build option ALU_ARB_RR_EN selects round-robin on contention (the port
// not granted last wins); otherwise port 0 has fixed priority.
// A single valid port is always granted in either mode.
module alu_arb_pick (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

`ifndef ALU_ARB_RR_EN
    // History is irrelevant with fixed priority.
    logic unused_last_s;
    assign unused_last_s = last_grant_i;
`endif

    // Choose a one-hot winner among the valid requesters.
    always_comb begin
        grant_o = 2'b00;
        if (valid_i == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            if (last_grant_i) begin
                grant_o = 2'b01;
            end else begin
                grant_o = 2'b10;
            end
`else
            grant_o = 2'b01;
`endif
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU between the core
// execute path (port 0) and the auxiliary path (port 1).
// One operation at a time: IDLE accepts, EXEC drives the ALU and captures,
// RESP presents the registered result to the granted port until taken.
// Build option ALU_ARB_RR_EN: round-robin arbitration (see alu_arb_pick).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    arb_state_e       state_q, state_d;
    // Operand/op registers double as the ALU drive: they only hold
    // non-zero values while in EXEC and are cleared on leaving it.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             err_q, err_d;
    logic             gnt_q, gnt_d;       // granted port id
    logic             last_q, last_d;     // last-grant pointer
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;

    logic [1:0]       grant_s;
    logic             idle_s;
    logic             rsp_take_s;

    alu_arb_pick u_pick (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_q),
        .grant_o      (grant_s)
    );

    assign idle_s     = (state_q == ST_IDLE);
    assign req0_ready = idle_s & grant_s[0];
    assign req1_ready = idle_s & grant_s[1];
    // Only the granted port's ready can release the response.
    assign rsp_take_s = gnt_q ? rsp1_ready : rsp0_ready;

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = op_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = rsp_err_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;

    // Next-state and datapath-load decisions for the accept/exec/resp sequence.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        err_d        = err_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        result_d     = result_q;
        zero_d       = zero_q;
        rsp_err_d    = rsp_err_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    if (grant_s[1]) begin
                        a_d   = req1_a;
                        b_d   = req1_b;
                        op_d  = alu_op_effective(req1_op);
                        err_d = ~alu_op_legal(req1_op);
                    end else begin
                        a_d   = req0_a;
                        b_d   = req0_b;
                        op_d  = alu_op_effective(req0_op);
                        err_d = ~alu_op_legal(req0_op);
                    end
                    gnt_d   = grant_s[1];
                    last_d  = grant_s[1];
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                result_d     = alu_result;
                zero_d       = alu_zero;
                rsp_err_d    = err_q;
                rsp0_valid_d = ~gnt_q;
                rsp1_valid_d = gnt_q;
                a_d          = {WIDTH{1'b0}};
                b_d          = {WIDTH{1'b0}};
                op_d         = 4'b0000;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_take_s) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d      = ST_RESP;
                end
            end
            default: begin
                a_d          = {WIDTH{1'b0}};
                b_d          = {WIDTH{1'b0}};
                op_d         = 4'b0000;
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            op_q         <= 4'b0000;
            err_q        <= 1'b0;
            gnt_q        <= 1'b0;
            last_q       <= 1'b1;
            result_q     <= {WIDTH{1'b0}};
            zero_q       <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            err_q        <= err_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            rsp_err_q    <= rsp_err_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational ALU between two requesters: port 0 is the core execute path, port 1 is the auxiliary path (address-generation / debug). Each request carries two operands and a 4-bit ALU control code. The block arbitrates between the ports, sequences one operation at a time through the ALU, registers the result, and returns it on a per-port valid/ready response channel. It sits between the requesters and the ALU instance that is driven by `alu_control`.

## Interface
- `WIDTH`, 32, operand and result width.
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req0_valid` input 1: port 0 request present.
- `req0_ready` output 1: port 0 request accepted this cycle.
- `req0_a`, `req0_b` input WIDTH: port 0 operands.
- `req0_op` input 4: port 0 ALU control code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: identical set for port 1.
- `rsp0_valid` output 1: result ready for port 0.
- `rsp0_ready` input 1: port 0 takes the result.
- `rsp1_valid` output 1: result ready for port 1.
- `rsp1_ready` input 1: port 1 takes the result.
- `rsp_result` output WIDTH: registered ALU result, shared by both ports.
- `rsp_zero` output 1: registered ALU zero flag.
- `rsp_err` output 1: the op code was illegal and was substituted.
- `alu_a`, `alu_b` output WIDTH: operands to the shared ALU.
- `alu_ctrl` output 4: control code to the shared ALU.
- `alu_result` input WIDTH: ALU result (combinational).
- `alu_zero` input 1: ALU zero flag.

## Operation
- Legal op codes: 0000 add, 0001 sub, 0010 sll, 0011 srl, 0100 sra, 0101 and, 0110 or, 0111 xor.
- Codes 1000–1111 are accepted. They are executed as 0000, and `rsp_err`=1 is returned with that response.
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - The arbiter picks a winner among the valid ports.
  - `reqN_ready`=1 only for the winner, combinationally.
  - On handshake: latch operands, op, error flag and grant id; go to EXEC.
  - With no valid request, stay in IDLE.
- **EXEC**
  - `alu_a`, `alu_b`, `alu_ctrl` are driven from the latched registers.
  - At the clock edge: capture `alu_result` and `alu_zero` into `rsp_result` and `rsp_zero`, then go to RESP.
- **RESP**
  - `rspN_valid`=1 for the granted port only.
  - `rsp_result`, `rsp_zero`, `rsp_err` are held stable.
  - On `rspN_ready`=1, go to IDLE. Ready on the other port is ignored.
- Outside EXEC, `alu_a`, `alu_b`, `alu_ctrl` are driven to 0.
- Both `reqN_ready` are 0 in EXEC and RESP, so a port's `valid` may stay high across a busy period.
- Reset asserted in any state:
  - Return to IDLE immediately.
  - The in-flight operation is dropped and no response is issued.
  - The last-grant pointer is reset.
- Arithmetic is performed by the external ALU. This block never modifies the operands or the result.

## Timing
- Reset values of all outputs are 0: `req*_ready`, `rsp*_valid`, `rsp_result`, `rsp_zero`, `rsp_err`, `alu_a`, `alu_b`, `alu_ctrl`.
  - The exception is `reqN_ready`, which is combinational and can be 1 in IDLE right after reset if `reqN_valid`=1.
- If the request handshake occurs at edge E0:
  - The ALU is driven during cycle E0→E1.
  - The result is captured at E1.
  - `rsp_valid` is high from E1.
- Minimum response latency is 1 cycle after acceptance.
- Minimum issue interval is 3 cycles when responses are taken immediately: accept, exec, resp, then IDLE.
- Back-pressure: RESP holds indefinitely until the matching `rsp_ready` is high.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - When both ports are valid, the port not granted last wins.
  - The last-grant pointer is updated on each request handshake.
  - It resets to 1, so port 0 wins the first contention.
- `ALU_ARB_RR_EN` undefined: fixed priority; port 0 always wins contention, and port 1 can starve.
- In both modes a single valid port is always granted.

## Structure
- Shared package `alu_pkg` holds:
  - The op-code localparams (ALU_ADD … ALU_XOR), so they match `alu_control`.
  - `ALU_OP_LAST` = 4'b0111.
  - The FSM state encoding.
- Sub-module `alu_arb_pick`: combinational 2-way picker with inputs valid[1:0] and last_grant, and output grant one-hot.
  - It contains the `ALU_ARB_RR_EN` logic.

## Test plan
- Port 0 only: `a`=5, `b`=3, op 0001, `rsp0_ready`=1.
  - Expect `req0_ready` at E0, `rsp0_valid` at E1 with result 2, `zero`=0, `err`=0.
  - `rsp1_valid` stays 0.
- Both valid, op xor and or, `a`=`b`=0xFFFF_FFFF.
  - With RR: grants alternate 0,1,0,1; xor returns 0 with `zero`=1.
  - Without RR: port 0 is granted every time.
- Illegal op 1010 on port 1 with `a`=7, `b`=8.
  - Expect `alu_ctrl`=0000 in EXEC, `rsp_result`=15, `rsp_err`=1.
- Hold `rsp0_ready`=0 for 5 cycles.
  - `rsp0_valid` and `rsp_result` stay stable; `req1_ready` stays 0 even though `req1_valid`=1.
  - Release: IDLE next, then port 1 is granted.
- Assert `rst_n`=0 during EXEC.
  - All outputs go to 0 asynchronously, no response is produced, and the FSM restarts in IDLE.
- sra with `a`=0x8000_0000, `b`=4 (op 0100) -> result 0xF800_0000.
